// File: rtl/full_subtractor_pkg.sv
// Shared definitions for the full subtractor cell and its bit-serial engine.
package full_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fs_state_e;

    // Counter must hold 0..WIDTH so a WIDTH of one still gets a real counter bit.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage : full_subtractor_pkg

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: D = a - b - bin, with borrow-out; purely combinational.
module full_subtractor_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Difference and borrow equations of the classic full subtractor.
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule : full_subtractor_cell

// File: rtl/full_subtractor_unit.sv
// Combinational full subtractor cell plus an LSB-first serial engine that reuses
// a second copy of the cell to subtract WIDTH-bit operands one bit per cycle.
module full_subtractor_unit
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             Bin,
    output logic             D,
    output logic             Bout,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    fs_state_e        state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;

    logic             ser_d_s;
    logic             ser_bout_s;
    logic [WIDTH:0]   res_ext_s;
    logic [WIDTH-1:0] res_d;

    full_subtractor_cell u_port_cell (
        .a_i    (a),
        .b_i    (b),
        .bin_i  (Bin),
        .d_o    (D),
        .bout_o (Bout)
    );

    full_subtractor_cell u_serial_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (borrow_q),
        .d_o    (ser_d_s),
        .bout_o (ser_bout_s)
    );

    // Result fills from the MSB side so the first (LSB) difference bit ends up in bit 0.
    always_comb begin
        res_ext_s = {ser_d_s, res_q};
        res_d     = res_ext_s[WIDTH:1];
    end

    // Serial sequencer: IDLE accepts start, RUN consumes one operand bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= {WIDTH{1'b0}};
            b_sh_q       <= {WIDTH{1'b0}};
            res_q        <= {WIDTH{1'b0}};
            borrow_q     <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= {WIDTH{1'b0}};
            borrow_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q   <= op_a;
                        b_sh_q   <= op_b;
                        borrow_q <= Bin;
                        cnt_q    <= {CNT_W{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= ser_bout_s;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Start seen on the completion edge is dropped: the engine is still in RUN.
                    if (cnt_q == LAST_CNT) begin
                        diff_q       <= res_d;
                        borrow_out_q <= ser_bout_s;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule : full_subtractor_unit

// File: tb/tb_full_subtractor_unit.sv
// Directed bench for full_subtractor_unit: cell truth table plus a scoreboard on the serial engine.
module tb_full_subtractor_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         a;
    logic         b;
    logic         Bin;
    logic         D;
    logic         Bout;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int           checks;
    int           errors;
    int           done_seen;
    logic [W:0]   exp_q[$];

    full_subtractor_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .Bin        (Bin),
        .D          (D),
        .Bout       (Bout),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // mode 0: plain, 1: second start mid-run, 2: start on the completion edge
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                          input logic [W-1:0] ed, input logic eb, input int mode);
        int  lat;
        bit  busy_ok;
        @(negedge clk);
        op_a  = xa;
        op_b  = xb;
        Bin   = xbin;
        start = 1'b1;
        exp_q.push_back({ed, eb});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (mode == 1 && lat == 3) begin
                op_a  = 8'hFF;
                op_b  = 8'h00;
                start = 1'b1;
            end else if (mode == 2 && lat == W - 1) begin
                op_a  = 8'h77;
                op_b  = 8'h11;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end else begin
            check("latency", lat, W);
            check("busy_during_run", busy_ok, 1'b1);
            check("busy_at_done", busy, 1'b0);
        end
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
        check("diff_hold", {diff, borrow_out}, {ed, eb});
    endtask

    initial begin
        logic [1:0] tbl [8];
        logic [2:0] idx;
        tbl = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        checks    = 0;
        errors    = 0;
        done_seen = 0;
        rst_n = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        Bin   = 1'b0;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;

        // Monitor: pops the scoreboard whenever the engine pulses done.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && done) begin
                    done_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: diff=%0h borrow=%0b", diff, borrow_out);
                    end else begin
                        logic [W:0] e;
                        e = exp_q.pop_front();
                        if ({diff, borrow_out} !== e) begin
                            errors++;
                            $display("FAIL serial_result: got diff=%0h borrow=%0b expected diff=%0h borrow=%0b",
                                     diff, borrow_out, e[W:1], e[0]);
                        end
                    end
                end
            end
        join_none

        #3;
        check("reset_outputs", {busy, done, diff, borrow_out}, 11'h000);
        #20;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            idx = i[2:0];
            {a, b, Bin} = idx;
            #1;
            check($sformatf("cell_%0b", idx), {D, Bout}, tbl[i]);
        end
        Bin = 1'b0;

        run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 0);
        run_op(8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 0);
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1);
        run_op(8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 0);

        // Abort a run with reset after three processed bits.
        @(negedge clk);
        op_a  = 8'h33;
        op_b  = 8'h11;
        Bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {busy, done, diff, borrow_out}, 11'h000);
        @(negedge clk);
        check("abort_no_done", done, 1'b0);
        rst_n = 1'b1;
        run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 0);

        run_op(8'hAA, 8'hAA, 1'b1, 8'hFF, 1'b1, 2);
        run_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 0);

        repeat (12) @(negedge clk);
        check("done_count", done_seen, 7);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_full_subtractor_unit
